// File: rtl/click.sv
// click: cursor-action block for the 8x8 game board.
// Turns rising edges of the select (reveal) and flag (mark) buttons into edits
// of the cell at matrizJuego[pos_y][pos_x]. Cell codes: 0 hidden, 1 flagged,
// 2 revealed. When both buttons rise together the flag action wins and the
// select edge is dropped.
// Optional feature: define CLICK_FLAG_LIMIT_EN to cap flagged cells at 10.
module click (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  select,
    input  logic                  flag,
    input  logic [2:0]            pos_x,
    input  logic [2:0]            pos_y,
    output logic [7:0][7:0][3:0]  matrizJuego
);

    localparam logic [3:0] CELL_HIDDEN   = 4'h0;
    localparam logic [3:0] CELL_FLAGGED  = 4'h1;
    localparam logic [3:0] CELL_REVEALED = 4'h2;

    logic       select_q;
    logic       flag_q;
    logic       sel_rise;
    logic       flag_rise;
    logic [3:0] cur_cell;
    logic       limit_hit;
    logic       flag_set;
    logic       flag_clr;
    logic       reveal;

    // Previous sampled button levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            select_q <= select;
            flag_q   <= flag;
        end
    end

    assign sel_rise  = select & ~select_q;
    assign flag_rise = flag & ~flag_q;
    assign cur_cell  = matrizJuego[pos_y][pos_x];

`ifdef CLICK_FLAG_LIMIT_EN
    logic [3:0] flag_count;

    assign limit_hit = (flag_count == 4'd10);

    // Number of cells currently flagged; reveals never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_count <= 4'd0;
        end else if (flag_set) begin
            flag_count <= flag_count + 4'd1;
        end else if (flag_clr) begin
            flag_count <= flag_count - 4'd1;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    // Decode the single action for this cycle; flag has priority over select.
    always_comb begin
        flag_set = 1'b0;
        flag_clr = 1'b0;
        reveal   = 1'b0;
        if (flag_rise) begin
            flag_set = (cur_cell == CELL_HIDDEN) && !limit_hit;
            flag_clr = (cur_cell == CELL_FLAGGED);
        end else if (sel_rise) begin
            reveal = (cur_cell == CELL_HIDDEN);
        end
    end

    // Board storage: only the addressed cell can change in a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrizJuego <= '0;
        end else if (flag_set) begin
            matrizJuego[pos_y][pos_x] <= CELL_FLAGGED;
        end else if (flag_clr) begin
            matrizJuego[pos_y][pos_x] <= CELL_HIDDEN;
        end else if (reveal) begin
            matrizJuego[pos_y][pos_x] <= CELL_REVEALED;
        end
    end

endmodule

// File: tb/tb_click.sv
// tb_click: self-checking bench for click. A behavioural board model
// (an 8x8 array of cell codes plus the last driven button levels) predicts
// the board after every clock; directed scenarios are followed by random play.
module tb_click;

    logic                 clk;
    logic                 rst;
    logic                 select;
    logic                 flag;
    logic [2:0]           pos_x;
    logic [2:0]           pos_y;
    logic [7:0][7:0][3:0] matrizJuego;

    int vectors;
    int miscompares;

    // Reference model state.
    int   model [8][8];
    logic prev_sel;
    logic prev_flag;

    click dut (
        .clk         (clk),
        .rst         (rst),
        .select      (select),
        .flag        (flag),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .matrizJuego (matrizJuego)
    );

    // Clock: posedges at 5, 15, 25 ...; negedges at 10, 20 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int flagged_cells();
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (model[r][c] == 1) n++;
        return n;
    endfunction

    function automatic logic [255:0] model_board();
        logic [255:0] b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[(r*8+c)*4 +: 4] = 4'(model[r][c]);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                model[r][c] = 0;
        prev_sel  = 1'b0;
        prev_flag = 1'b0;
    endtask

    // Game rules: a press is new when the button was low on the previous clock.
    task automatic model_clock(input logic s, input logic f, input int x, input int y);
        bit new_sel  = s && !prev_sel;
        bit new_flag = f && !prev_flag;
        bit full;
`ifdef CLICK_FLAG_LIMIT_EN
        full = (flagged_cells() >= 10);
`else
        full = 1'b0;
`endif
        if (new_flag) begin
            if (model[y][x] == 0 && !full) model[y][x] = 1;
            else if (model[y][x] == 1)     model[y][x] = 0;
        end else if (new_sel) begin
            if (model[y][x] == 0) model[y][x] = 2;
        end
        prev_sel  = s;
        prev_flag = f;
    endtask

    // Entered just after a negedge: drive, clock once, compare, return at next negedge.
    task automatic cycle(input string tag, input logic s, input logic f, input int x, input int y);
        select = s;
        flag   = f;
        pos_x  = 3'(x);
        pos_y  = 3'(y);
        @(posedge clk);
        #1;
        model_clock(s, f, x, y);
        check(tag, matrizJuego, model_board());
        @(negedge clk);
    endtask

    task automatic pulse_flag(input string tag, input int x, input int y);
        cycle(tag, 1'b0, 1'b1, x, y);
        cycle(tag, 1'b0, 1'b0, x, y);
    endtask

    task automatic pulse_sel(input string tag, input int x, input int y);
        cycle(tag, 1'b1, 1'b0, x, y);
        cycle(tag, 1'b0, 1'b0, x, y);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        select = 1'b0;
        flag = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        select = 1'b0;
        flag   = 1'b0;
        pos_x  = 3'd0;
        pos_y  = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_board", matrizJuego, '0);
        rst = 1'b0;

        // Single flag pulse at (3,4).
        pulse_flag("flag_3_4", 3, 4);
        check("cell_4_3_flagged", 256'(matrizJuego[4][3]), 256'd1);

        // Held flag at (4,3) toggles exactly once.
        for (int i = 0; i < 10; i++) cycle("hold_flag", 1'b0, 1'b1, 4, 3);
        cycle("hold_release", 1'b0, 1'b0, 4, 3);
        check("cell_3_4_once", 256'(matrizJuego[3][4]), 256'd1);
        check("cell_4_3_kept", 256'(matrizJuego[4][3]), 256'd1);
        pulse_flag("unflag_4_3", 4, 3);
        check("cell_3_4_clear", 256'(matrizJuego[3][4]), 256'd0);

        // Flag protects from reveal; revealed cells are final.
        pulse_flag("reflag", 4, 3);
        pulse_sel("sel_on_flag", 4, 3);
        check("flag_protects", 256'(matrizJuego[3][4]), 256'd1);
        pulse_flag("unflag_again", 4, 3);
        pulse_sel("reveal", 4, 3);
        check("revealed", 256'(matrizJuego[3][4]), 256'd2);
        pulse_flag("flag_on_revealed", 4, 3);
        pulse_sel("sel_on_revealed", 4, 3);
        check("revealed_final", 256'(matrizJuego[3][4]), 256'd2);

        // Simultaneous rising edges: flag wins, select edge is dropped.
        cycle("both_rise", 1'b1, 1'b1, 0, 0);
        cycle("sel_held", 1'b1, 1'b0, 0, 0);
        check("no_deferred_reveal", 256'(matrizJuego[0][0]), 256'd1);
        cycle("both_low", 1'b0, 1'b0, 0, 0);
        pulse_sel("lone_sel", 0, 0);
        check("lone_sel_blocked", 256'(matrizJuego[0][0]), 256'd1);

        // Asynchronous reset between clock edges.
        pulse_flag("pre_rst_a", 5, 5);
        pulse_flag("pre_rst_b", 6, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clear", matrizJuego, '0);
        model_reset();
        // Button held across reset release acts at the first clock.
        flag  = 1'b1;
        pos_x = 3'd1;
        pos_y = 3'd1;
        @(negedge clk);
        rst = 1'b0;
        cycle("held_through_rst", 1'b0, 1'b1, 1, 1);
        check("held_rst_edge", 256'(matrizJuego[1][1]), 256'd1);
        cycle("release", 1'b0, 1'b0, 1, 1);

        // Flag limit: ten distinct cells, then an eleventh.
        sync_reset();
        for (int i = 0; i < 10; i++) pulse_flag("fill", i % 8, 5 + i / 8);
        pulse_flag("eleventh", 2, 6);
`ifdef CLICK_FLAG_LIMIT_EN
        check("eleventh_refused", 256'(matrizJuego[6][2]), 256'd0);
`else
        check("eleventh_allowed", 256'(matrizJuego[6][2]), 256'd1);
        pulse_flag("eleventh_undo", 2, 6);
`endif
        pulse_flag("unflag_one", 0, 5);
        pulse_flag("eleventh_retry", 2, 6);
        check("eleventh_retry_ok", 256'(matrizJuego[6][2]), 256'd1);

        // Random play against the model.
        sync_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle("random",
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
            if ((i % 500) == 499) sync_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
